// File: rtl/sound_pkg.sv
// Shared types, default widths and field-extraction helper for the buzzer arbiter
// and related shared-peripheral arbiters.
package sound_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TONE = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam int unsigned DIV_W       = 16;
    localparam int unsigned DUR_W       = 24;
    localparam int unsigned SLICE_BUS_W = 256;
    localparam int unsigned SLICE_W     = 32;

    // Returns field idx of width w from a flattened per-requester bus, zero-extended.
    function automatic logic [SLICE_W-1:0] sel_slice(
        input logic [SLICE_BUS_W-1:0] bus,
        input int unsigned            idx,
        input int unsigned            w
    );
        logic [SLICE_BUS_W-1:0] sh;
        logic [SLICE_W-1:0]     mask;
        sh   = bus >> (idx * w);
        mask = (w >= SLICE_W) ? '1 : SLICE_W'((64'(1) << w) - 64'(1));
        return SLICE_W'(sh) & mask;
    endfunction

endpackage

// File: rtl/sound_rr_pick.sv
// Combinational round-robin selector: first set request after index last, wrapping.
module sound_rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [N_REQ-1:0] gnt_c,
    output logic [IDX_W-1:0] idx_c,
    output logic             valid_c
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_c   = '0;
        idx_c   = '0;
        valid_c = 1'b0;
        cand    = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((32'(last) + k) % N_REQ);
            if (!valid_c && req[cand]) begin
                valid_c     = 1'b1;
                idx_c       = cand;
                gnt_c[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sound_arbiter.sv
// Round-robin owner of the board buzzer: one non-preemptible square-wave tone per
// grant, a one-cycle acknowledge, then an enforced silent gap.
module sound_arbiter
    import sound_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned DIV_W   = sound_pkg::DIV_W,
    parameter int unsigned DUR_W   = sound_pkg::DUR_W,
    parameter int unsigned GAP_CYC = 1000000
) (
    input  logic                   iCLK,
    input  logic                   iRST_N,
    input  logic [N_REQ-1:0]       iREQ,
    input  logic [N_REQ*DIV_W-1:0] iDIV,
    input  logic [N_REQ*DUR_W-1:0] iDUR,
    input  logic                   iMUTE,
    output logic [N_REQ-1:0]       oGNT,
    output logic [N_REQ-1:0]       oACK,
    output logic                   oBUSY,
    output logic                   oSOUND
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned GAP_W = $clog2(GAP_CYC + 1);

    state_e             state_q,    state_d;
    logic [IDX_W-1:0]   last_q,     last_d;
    logic [DIV_W-1:0]   div_q,      div_d;
    logic [DIV_W-1:0]   half_cnt_q, half_cnt_d;
    logic [DUR_W-1:0]   dur_cnt_q,  dur_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q,  gap_cnt_d;
    logic               tone_q,     tone_d;
    logic [N_REQ-1:0]   gnt_q,      gnt_d;
    logic [N_REQ-1:0]   ack_q,      ack_d;
    logic               busy_q,     busy_d;
    logic               sound_q,    sound_d;

    logic [N_REQ-1:0]   pick_gnt_c;
    logic [IDX_W-1:0]   pick_idx_c;
    logic               pick_valid_c;
    logic [DIV_W-1:0]   div_in_c;
    logic [DUR_W-1:0]   dur_in_c;

    sound_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req     (iREQ),
        .last    (last_q),
        .gnt_c   (pick_gnt_c),
        .idx_c   (pick_idx_c),
        .valid_c (pick_valid_c)
    );

    // Winner's fields, only consumed on the IDLE->TONE transition.
    assign div_in_c = DIV_W'(sel_slice(SLICE_BUS_W'(iDIV), 32'(pick_idx_c), DIV_W));
    assign dur_in_c = DUR_W'(sel_slice(SLICE_BUS_W'(iDUR), 32'(pick_idx_c), DUR_W));

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        div_d      = div_q;
        half_cnt_d = half_cnt_q;
        dur_cnt_d  = dur_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        tone_d     = tone_q;
        gnt_d      = gnt_q;
        ack_d      = '0;
        busy_d     = busy_q;
        sound_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_valid_c) begin
                    state_d    = TONE;
                    last_d     = pick_idx_c;
                    div_d      = div_in_c;
                    half_cnt_d = '0;
                    // Remaining cycles after the first; a zero duration plays one cycle.
                    dur_cnt_d  = (dur_in_c == '0) ? '0 : dur_in_c - DUR_W'(1);
                    tone_d     = (div_in_c != '0);
                    gnt_d      = pick_gnt_c;
                    busy_d     = 1'b1;
                    sound_d    = tone_d && !iMUTE;
                end
            end

            TONE: begin
                if (div_q != '0) begin
                    if (half_cnt_q == div_q - DIV_W'(1)) begin
                        half_cnt_d = '0;
                        tone_d     = !tone_q;
                    end else begin
                        half_cnt_d = half_cnt_q + DIV_W'(1);
                    end
                end
                if (dur_cnt_q == '0) begin
                    state_d   = GAP;
                    gnt_d     = '0;
                    ack_d     = gnt_q;
                    gap_cnt_d = GAP_W'(GAP_CYC);
                end else begin
                    dur_cnt_d = dur_cnt_q - DUR_W'(1);
                    sound_d   = tone_d && !iMUTE;
                end
            end

            GAP: begin
                if (gap_cnt_q <= GAP_W'(1)) begin
                    state_d   = IDLE;
                    gap_cnt_d = '0;
                    busy_d    = 1'b0;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q    <= IDLE;
            last_q     <= IDX_W'(N_REQ - 1);
            div_q      <= '0;
            half_cnt_q <= '0;
            dur_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            tone_q     <= 1'b0;
            gnt_q      <= '0;
            ack_q      <= '0;
            busy_q     <= 1'b0;
            sound_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            div_q      <= div_d;
            half_cnt_q <= half_cnt_d;
            dur_cnt_q  <= dur_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            tone_q     <= tone_d;
            gnt_q      <= gnt_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            sound_q    <= sound_d;
        end
    end

    assign oGNT   = gnt_q;
    assign oACK   = ack_q;
    assign oBUSY  = busy_q;
    assign oSOUND = sound_q;

endmodule

// File: doc/sound_arbiter.md
Name: sound_arbiter

Overview:
- Shares the single board buzzer output among N_REQ requesters (key beep, alarm, status chirp, …).
- Each requester supplies a square-wave half-period and a tone duration.
- The block grants the buzzer round-robin, plays one non-preemptible tone, acknowledges the requester, then enforces a silent gap before the next grant.
- Sits between the system control logic and the buzzer pin. It replaces free-running divider/gating of the sound output.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DIV_W, 16, width of the half-period field, in clock cycles.
- DUR_W, 24, width of the duration field, in clock cycles.
- GAP_CYC, 1000000, silent cycles enforced after every tone (>=1).

Ports:
- iCLK  in  1  system clock.
- iRST_N  in  1  asynchronous active-low reset.
- iREQ  in  N_REQ  level request per requester.
- iDIV  in  N_REQ*DIV_W  half-period per requester; slice i = bits [i*DIV_W +: DIV_W].
- iDUR  in  N_REQ*DUR_W  tone length per requester; slice i as above.
- iMUTE  in  1  forces silence without stopping sequencing.
- oGNT  out  N_REQ  one-hot grant; high for the whole tone.
- oACK  out  N_REQ  one-cycle pulse when the granted tone completes.
- oBUSY  out  1  high in TONE and GAP.
- oSOUND  out  1  registered buzzer drive.

Behaviour:
- Single clock iCLK. Reset is asynchronous and active-low on iRST_N.
- Reset values:
  - state = IDLE.
  - oGNT = 0, oACK = 0, oBUSY = 0, oSOUND = 0.
  - Round-robin pointer last = N_REQ-1, so requester 0 has first priority.
  - All counters = 0.
- States:
  - IDLE: if any iREQ is set at edge t, pick the first set bit searching last+1, last+2, … modulo N_REQ. Latch that slot's iDIV and iDUR. Set last = winner. Enter TONE at t+1.
  - TONE (cycles t+1 .. t+D):
    - oGNT = one-hot winner, oBUSY = 1.
    - D = latched duration; a duration of 0 is treated as 1.
    - Half-period counter counts 0..DIV-1. On reaching DIV-1, the tone bit toggles and the counter clears.
    - The tone bit is 1 in the first TONE cycle.
    - DIV = 0 means a silent tone: the tone bit stays 0 for the full duration.
    - DIV = 1 toggles every cycle.
  - Entering GAP (edge t+D+1):
    - oGNT = 0, oSOUND = 0.
    - oACK[winner] = 1 for exactly one cycle.
    - Gap counter loads GAP_CYC.
  - GAP: lasts GAP_CYC cycles, oBUSY = 1, then IDLE. Earliest next grant starts TONE GAP_CYC+2 cycles after TONE ends.
- oSOUND is registered every cycle: oSOUND = tone bit AND NOT iMUTE, when in TONE; otherwise 0.
  - iMUTE therefore takes effect one cycle late.
  - Counters and acknowledge are unaffected by iMUTE.
- Non-preemptive:
  - Changes to iREQ, iDIV or iDUR during TONE/GAP are ignored.
  - A requester that drops iREQ mid-tone still receives oACK.
- A requester holding iREQ after oACK is re-arbitrated normally. Round-robin guarantees every active requester a grant within N_REQ tones.
- Reset mid-tone: all outputs go to reset values immediately (asynchronously); no oACK is issued.
- Counter widths: the half-period counter is DIV_W bits, the duration counter DUR_W bits, and the gap counter $clog2(GAP_CYC+1) bits. No overflow is possible by construction.

Decomposition:
- Shared package sound_pkg holds:
  - state enum {IDLE, TONE, GAP};
  - default width constants DIV_W and DUR_W;
  - function sel_slice for extracting per-requester fields.
- Sub-module sound_rr_pick: purely combinational round-robin selector.
  - Inputs: req vector and last index.
  - Outputs: one-hot grant, winner index and valid.
  - Reused by future shared-peripheral arbiters.
- The FSM, counters and output register stay in sound_arbiter.

Test Plan:
- Reset release, no requests -> oSOUND/oGNT/oACK/oBUSY stay 0 for 100 cycles.
- iREQ=0001, DIV=3, DUR=12, GAP_CYC=5, iREQ dropped at grant -> expected response:
  - oGNT=0001 for 12 cycles;
  - oSOUND pattern 111000111000;
  - oACK[0] pulses on cycle 13;
  - oBUSY low again after 5 gap cycles.
- iREQ=1111 held continuously with ack-based release -> grant order 0,1,2,3; each oACK once; no overlap of oGNT bits.
- iREQ[2] held, iMUTE asserted mid-tone -> oSOUND 0 from the next cycle onward; oACK[2] still arrives at the scheduled cycle.
- Boundary values, run separately:
  - DIV=0, DUR=4 -> silent 4-cycle TONE with ack;
  - DUR=0 -> 1-cycle TONE with ack;
  - DIV=1 -> oSOUND toggles every cycle.
- iRST_N pulsed low mid-TONE -> all outputs 0 immediately; no oACK; after release, requester 0 has first priority again.
